uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed frame from the receiver's parallel output into a circular FIFO, and records parity and framing errors as saturating counters. It also flags overrun when the host drains too slowly. The host side reads words through a single-cycle read strobe with a registered data output.

---
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind a UART receiver: edge-detected frame capture,
// registered host reads, overrun flag and saturating parity/framing error counters.
module uart_rx_fifo #(
    parameter int data_wd   = 8,
    parameter int depth     = 16,
    parameter int afull_lvl = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_done,
    input  logic [data_wd-1:0]           rx_dout,
    input  logic                         parity_error_flag,
    input  logic                         framing_error_flag,
    input  logic                         rd_en,
    input  logic                         clr_status,
    output logic [data_wd-1:0]           rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         overrun,
    output logic [7:0]                   parity_err_cnt,
    output logic [7:0]                   framing_err_cnt
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [data_wd-1:0] mem [depth];
    logic [aw-1:0]      wptr;
    logic [aw-1:0]      rptr;
    logic               rx_done_q;
    logic               parity_q;
    logic               framing_q;

    logic wr_ev;
    logic parity_ev;
    logic framing_ev;
    logic rd_ok;
    logic wr_ok;

    always_comb begin
        wr_ev       = rx_done && !rx_done_q;
        parity_ev   = parity_error_flag && !parity_q;
        framing_ev  = framing_error_flag && !framing_q;
        empty       = (count == '0);
        full        = (count == cw'(depth));
        almost_full = (count >= cw'(afull_lvl));
        rd_ok       = rd_en && !empty;
        // A read in the same cycle frees the slot being overwritten, so a full FIFO still accepts.
        wr_ok       = wr_ev && (!full || rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= rx_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_done_q <= 1'b0;
            parity_q  <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            parity_q  <= parity_error_flag;
            framing_q <= framing_error_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + aw'(1);
            end
            if (rd_ok) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + aw'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun         <= 1'b0;
            parity_err_cnt  <= '0;
            framing_err_cnt <= '0;
        end else if (clr_status) begin
            overrun         <= 1'b0;
            parity_err_cnt  <= '0;
            framing_err_cnt <= '0;
        end else begin
            if (wr_ev && !wr_ok) begin
                overrun <= 1'b1;
            end
            if (parity_ev && (parity_err_cnt != '1)) begin
                parity_err_cnt <= parity_err_cnt + 8'd1;
            end
            if (framing_ev && (framing_err_cnt != '1)) begin
                framing_err_cnt <= framing_err_cnt + 8'd1;
            end
        end
    end

endmodule
